// File: rtl/foosball_pkg.sv
// Shared types and defaults for the foosball rod, draw and collision blocks.
package foosball_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned CALC_W  = COORD_W + 1;
  localparam int unsigned CNT_W   = 8;

  localparam int unsigned DEF_Y_MIN           = 0;
  localparam int unsigned DEF_Y_MAX           = 300;
  localparam int unsigned DEF_Y_INIT          = 150;
  localparam int unsigned DEF_STEP            = 4;
  localparam int unsigned DEF_KICK_FRAMES     = 6;
  localparam int unsigned DEF_COOLDOWN_FRAMES = 20;

  typedef enum logic [1:0] {
    StIdle,
    StKick,
    StCooldown
  } rod_state_t;

endpackage

// File: rtl/rod_player_fsm.sv
// One player's rod: kick key edge detect, pending kick, kick/cooldown FSM and clamped motion.
module rod_player_fsm
  import foosball_pkg::*;
#(
  parameter int unsigned Y_MIN           = DEF_Y_MIN,
  parameter int unsigned Y_MAX           = DEF_Y_MAX,
  parameter int unsigned Y_INIT          = DEF_Y_INIT,
  parameter int unsigned STEP            = DEF_STEP,
  parameter int unsigned KICK_FRAMES     = DEF_KICK_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               tick_i,
  input  logic               running_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               right_i,
  output logic [COORD_W-1:0] y_o,
  output logic               kick_o,
  output logic               strobe_o
);

  localparam logic [CALC_W-1:0] StepW = CALC_W'(STEP);
  localparam logic [CALC_W-1:0] MinW  = CALC_W'(Y_MIN);
  localparam logic [CALC_W-1:0] MaxW  = CALC_W'(Y_MAX);
  localparam logic [CALC_W-1:0] LoLim = MinW + StepW;

  rod_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               pend_q, pend_d;
  logic               right_q;
  logic               strobe_q, strobe_d;
  logic               kick_q;
  logic [CALC_W-1:0]  y_ext, y_calc;

  assign y_ext = {1'b0, y_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    strobe_d = 1'b0;
    y_calc   = y_ext;
    if (tick_i) begin
      pend_d = 1'b0;
      if (state_q != StKick) begin
        if (up_i && !down_i) begin
          // Compare before subtracting so a wrap below zero can never escape the clamp.
          y_calc = (y_ext < LoLim) ? MinW : y_ext - StepW;
        end else if (down_i && !up_i) begin
          y_calc = (y_ext + StepW > MaxW) ? MaxW : y_ext + StepW;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            state_d  = StKick;
            cnt_d    = CNT_W'(KICK_FRAMES - 1);
            strobe_d = 1'b1;
          end
        end
        StKick: begin
          if (cnt_q == '0) begin
            if (COOLDOWN_FRAMES == 0) begin
              state_d = StIdle;
            end else begin
              state_d = StCooldown;
              cnt_d   = CNT_W'(COOLDOWN_FRAMES - 1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StCooldown: begin
          if (cnt_q == '0) state_d = StIdle;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = StIdle;
      endcase
    end
    // Set after the tick clear: an edge coinciding with a tick is served on the next tick.
    if (running_i && right_i && !right_q) pend_d = 1'b1;
    y_d = y_calc[COORD_W-1:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      y_q      <= COORD_W'(Y_INIT);
      pend_q   <= 1'b0;
      right_q  <= 1'b0;
      strobe_q <= 1'b0;
      kick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      pend_q   <= pend_d;
      right_q  <= right_i;
      strobe_q <= strobe_d;
      kick_q   <= (state_d == StKick);
    end
  end

  assign y_o      = y_q;
  assign kick_o   = kick_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/rod_motion_ctrl.sv
// Both players' rods plus the space-key run/pause toggle; motion advances only on frame ticks.
module rod_motion_ctrl
  import foosball_pkg::*;
#(
  parameter int unsigned Y_MIN           = DEF_Y_MIN,
  parameter int unsigned Y_MAX           = DEF_Y_MAX,
  parameter int unsigned Y_INIT          = DEF_Y_INIT,
  parameter int unsigned STEP            = DEF_STEP,
  parameter int unsigned KICK_FRAMES     = DEF_KICK_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               space,
  input  logic               up_direction,
  input  logic               down_direction,
  input  logic               right_direction,
  input  logic               up2_direction,
  input  logic               down2_direction,
  input  logic               right2_direction,
  output logic               running,
  output logic [COORD_W-1:0] rod1_y,
  output logic [COORD_W-1:0] rod2_y,
  output logic               kick1,
  output logic               kick2,
  output logic               kick1_strobe,
  output logic               kick2_strobe
);

  logic space_q, space_qq;
  logic running_q;
  logic tick;

  // Edge taken between the input register and its delayed copy, so running moves two cycles
  // after the pin.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      space_q   <= 1'b0;
      space_qq  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      space_q  <= space;
      space_qq <= space_q;
      if (space_q && !space_qq) running_q <= !running_q;
    end
  end

  assign tick    = startOfFrame && running_q;
  assign running = running_q;

  rod_player_fsm #(
    .Y_MIN          (Y_MIN),
    .Y_MAX          (Y_MAX),
    .Y_INIT         (Y_INIT),
    .STEP           (STEP),
    .KICK_FRAMES    (KICK_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_player1 (
    .clk      (clk),
    .resetN   (resetN),
    .tick_i   (tick),
    .running_i(running_q),
    .up_i     (up_direction),
    .down_i   (down_direction),
    .right_i  (right_direction),
    .y_o      (rod1_y),
    .kick_o   (kick1),
    .strobe_o (kick1_strobe)
  );

  rod_player_fsm #(
    .Y_MIN          (Y_MIN),
    .Y_MAX          (Y_MAX),
    .Y_INIT         (Y_INIT),
    .STEP           (STEP),
    .KICK_FRAMES    (KICK_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_player2 (
    .clk      (clk),
    .resetN   (resetN),
    .tick_i   (tick),
    .running_i(running_q),
    .up_i     (up2_direction),
    .down_i   (down2_direction),
    .right_i  (right2_direction),
    .y_o      (rod2_y),
    .kick_o   (kick2),
    .strobe_o (kick2_strobe)
  );

endmodule

// File: tb/tb_rod_motion_ctrl.sv
// Bench for rod_motion_ctrl: reference model feeding a scoreboard, plus a hand-derived vector table.
module tb_rod_motion_ctrl;

  localparam int KF   = 6;
  localparam int CF   = 20;
  localparam int YI   = 150;
  localparam int YMIN = 0;
  localparam int YMAX = 300;
  localparam int STP  = 4;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        space;
  logic        up_direction, down_direction, right_direction;
  logic        up2_direction, down2_direction, right2_direction;
  logic        running;
  logic [10:0] rod1_y, rod2_y;
  logic        kick1, kick2, kick1_strobe, kick2_strobe;

  rod_motion_ctrl #(
    .Y_MIN          (YMIN),
    .Y_MAX          (YMAX),
    .Y_INIT         (YI),
    .STEP           (STP),
    .KICK_FRAMES    (KF),
    .COOLDOWN_FRAMES(CF)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .space           (space),
    .up_direction    (up_direction),
    .down_direction  (down_direction),
    .right_direction (right_direction),
    .up2_direction   (up2_direction),
    .down2_direction (down2_direction),
    .right2_direction(right2_direction),
    .running         (running),
    .rod1_y          (rod1_y),
    .rod2_y          (rod2_y),
    .kick1           (kick1),
    .kick2           (kick2),
    .kick1_strobe    (kick1_strobe),
    .kick2_strobe    (kick2_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] y1, y2;
    logic        k1, k2, s1, s2;
  } exp_t;

  typedef struct {
    logic        u1, d1, r1, u2, d2, r2;
    logic [10:0] y1, y2;
    logic        k1, k2, s1, s2;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[4];
  int   checks;
  int   errors;

  // Model: kick ticks left, cooldown ticks left, pending request, position.
  int m_y[2];
  int m_kl[2];
  int m_cl[2];
  bit m_pend[2];
  bit m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_y[p] = YI; m_kl[p] = 0; m_cl[p] = 0; m_pend[p] = 1'b0;
    end
    m_run = 1'b0;
  endtask

  task automatic model_tick(output exp_t e);
    bit u[2], d[2], s[2];
    u[0] = up_direction;  d[0] = down_direction;
    u[1] = up2_direction; d[1] = down2_direction;
    s[0] = 1'b0; s[1] = 1'b0;
    if (m_run) begin
      for (int p = 0; p < 2; p++) begin
        if (m_kl[p] > 0) begin
          m_kl[p]--;
          if (m_kl[p] == 0) m_cl[p] = CF;
        end else begin
          if (u[p] && !d[p]) m_y[p] = (m_y[p] - STP < YMIN) ? YMIN : m_y[p] - STP;
          else if (d[p] && !u[p]) m_y[p] = (m_y[p] + STP > YMAX) ? YMAX : m_y[p] + STP;
          if (m_cl[p] > 0) m_cl[p]--;
          else if (m_pend[p]) begin
            m_kl[p] = KF;
            s[p] = 1'b1;
          end
        end
        m_pend[p] = 1'b0;
      end
    end
    e.y1 = 11'(m_y[0]); e.y2 = 11'(m_y[1]);
    e.k1 = (m_kl[0] > 0); e.k2 = (m_kl[1] > 0);
    e.s1 = s[0]; e.s2 = s[1];
  endtask

  // Optional right-key taps, then one frame tick; expectation queued at the tick, checked after.
  task automatic frame(input logic u1, d1, r1, u2, d2, r2);
    exp_t e, got;
    up_direction  = u1; down_direction  = d1;
    up2_direction = u2; down2_direction = d2;
    if (r1 || r2) begin
      right_direction = r1; right2_direction = r2;
      cyc(1);
      right_direction = 1'b0; right2_direction = 1'b0;
      if (m_run) begin
        if (r1) m_pend[0] = 1'b1;
        if (r2) m_pend[1] = 1'b1;
      end
    end
    cyc(1);
    startOfFrame = 1'b1;
    model_tick(e);
    sb.push_back(e);
    cyc(1);
    startOfFrame = 1'b0;
    got = sb.pop_front();
    check("rod1_y", 32'(rod1_y), 32'(got.y1));
    check("rod2_y", 32'(rod2_y), 32'(got.y2));
    check("kick1", 32'(kick1), 32'(got.k1));
    check("kick2", 32'(kick2), 32'(got.k2));
    check("kick1_strobe", 32'(kick1_strobe), 32'(got.s1));
    check("kick2_strobe", 32'(kick2_strobe), 32'(got.s2));
    cyc(1);
    check("strobe1_one_cycle", 32'(kick1_strobe), 32'd0);
    check("strobe2_one_cycle", 32'(kick2_strobe), 32'd0);
  endtask

  task automatic press_space(input int hold);
    space = 1'b1;
    cyc(1);
    check("running_latency", 32'(running), 32'(m_run));
    cyc(1);
    m_run = !m_run;
    check("running_toggle", 32'(running), 32'(m_run));
    cyc(hold);
    check("running_hold", 32'(running), 32'(m_run));
    space = 1'b0;
    cyc(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_rod1_y"}, 32'(rod1_y), 32'(YI));
    check({tag, "_rod2_y"}, 32'(rod2_y), 32'(YI));
    check({tag, "_kick1"}, 32'(kick1), 32'd0);
    check({tag, "_kick2"}, 32'(kick2), 32'd0);
    check({tag, "_strobe1"}, 32'(kick1_strobe), 32'd0);
    check({tag, "_strobe2"}, 32'(kick2_strobe), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0; startOfFrame = 1'b0; space = 1'b0;
    up_direction = 1'b0; down_direction = 1'b0; right_direction = 1'b0;
    up2_direction = 1'b0; down2_direction = 1'b0; right2_direction = 1'b0;
    model_reset();

    // u1 d1 r1 u2 d2 r2 | y1 y2 | k1 k2 s1 s2 ; starts at 150/150, idle, running
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd146, 11'd154, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd142, 11'd150, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd142, 11'd150, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd142, 11'd150, 1'b1, 1'b1, 1'b0, 1'b0};

    cyc(3);
    check_reset_outputs("reset");
    resetN = 1'b1;
    cyc(2);

    // Start the game, then keep space held for 100 cycles.
    press_space(100);

    // Dual-player table, ending with both rods mid-kick.
    for (int i = 0; i < 4; i++) begin
      frame(tbl[i].u1, tbl[i].d1, tbl[i].r1, tbl[i].u2, tbl[i].d2, tbl[i].r2);
      check("tbl_rod1_y", 32'(rod1_y), 32'(tbl[i].y1));
      check("tbl_rod2_y", 32'(rod2_y), 32'(tbl[i].y2));
      check("tbl_kick1", 32'(kick1), 32'(tbl[i].k1));
      check("tbl_kick2", 32'(kick2), 32'(tbl[i].k2));
    end

    // Asynchronous reset mid-kick, away from the clock edge.
    #2;
    resetN = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    sb.delete();
    cyc(1);
    resetN = 1'b1;
    cyc(1);
    press_space(2);

    // Clamp at top and bottom, and both keys held.
    repeat (40) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clamp_top", 32'(rod1_y), 32'(YMIN));
    repeat (80) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clamp_bottom", 32'(rod1_y), 32'(YMAX));
    repeat (3) frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("both_keys_hold", 32'(rod1_y), 32'(YMAX));

    // Kick with up held, retap 3 ticks into cooldown, then retap once cooldown ends.
    frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("kick_start", 32'(kick1), 32'd1);
    for (int t = 1; t <= 26; t++) frame(1'b1, 1'b0, (t == 9), 1'b0, 1'b0, 1'b0);
    check("cooldown_done_idle", 32'(kick1), 32'd0);
    frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rekick", 32'(kick1), 32'd1);

    // Pause after two kick ticks; ticks and key edges while paused must do nothing.
    repeat (2) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    press_space(1);
    repeat (9) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("paused_kick_held", 32'(kick1), 32'd1);
    press_space(1);
    repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_kick_remaining", 32'(kick1), 32'd1);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_kick_end", 32'(kick1), 32'd0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("paused_edge_discarded", 32'(kick2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
